// File: rtl/lsu_sram.sv
// lsu_sram: converts EX-stage load/store requests into a handshaked SRAM-like
// bus (req/addr_ok/data_ok). It aligns byte lanes, extracts loads and flags
// misaligned accesses.
// Optional build macro LSU_PERF_CNT_EN adds load/store/stall counters.
//
// state | meaning
// IDLE  | no access outstanding, accepting a new op from EX
// REQ   | data_req asserted, waiting for addr_ok
// WAIT  | request accepted, waiting for data_ok to return the result
// DRAIN | access was flushed after acceptance, swallow its data_ok
module lsu_sram #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_ls_ena,
  input  logic [3:0]        ex_ls_sel,
  input  logic [ADDR_W-1:0] ex_addr,
  input  logic [31:0]       ex_wdata,
  input  logic              flush,
  output logic              lsu_stall,
  output logic [31:0]       mem_r_data,
  output logic              mem_r_valid,
  output logic              ls_adel,
  output logic              ls_ades,
  output logic [ADDR_W-1:0] ls_badvaddr,
  output logic              data_req,
  output logic              data_wr,
  output logic [1:0]        data_size,
  output logic [3:0]        data_wstrb,
  output logic [ADDR_W-1:0] data_addr,
  output logic [31:0]       data_wdata,
  input  logic              data_addr_ok,
  input  logic [31:0]       data_rdata,
`ifdef LSU_PERF_CNT_EN
  output logic [31:0]       perf_loads,
  output logic [31:0]       perf_stores,
  output logic [31:0]       perf_stall_cycles,
`endif
  input  logic              data_data_ok
);

  // Operation codes shared with the ID stage definitions.
  localparam logic [3:0] LS_SEL_LB  = 4'd0;
  localparam logic [3:0] LS_SEL_LBU = 4'd1;
  localparam logic [3:0] LS_SEL_LH  = 4'd2;
  localparam logic [3:0] LS_SEL_LHU = 4'd3;
  localparam logic [3:0] LS_SEL_LW  = 4'd4;
  localparam logic [3:0] LS_SEL_SB  = 4'd5;
  localparam logic [3:0] LS_SEL_SH  = 4'd6;
  localparam logic [3:0] LS_SEL_SW  = 4'd7;

  if (DATA_W != 32) begin : g_bad_data_w
    $error("lsu_sram: DATA_W must be 32");
  end
  if (ADDR_W < 3) begin : g_bad_addr_w
    $error("lsu_sram: ADDR_W must be at least 3");
  end

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DRAIN} state_e;

  function automatic logic sel_known(input logic [3:0] s);
    return s <= LS_SEL_SW;
  endfunction

  function automatic logic sel_store(input logic [3:0] s);
    return (s == LS_SEL_SB) || (s == LS_SEL_SH) || (s == LS_SEL_SW);
  endfunction

  function automatic logic [1:0] sel_size(input logic [3:0] s);
    logic [1:0] sz;
    case (s)
      LS_SEL_LB, LS_SEL_LBU, LS_SEL_SB: sz = 2'd0;
      LS_SEL_LH, LS_SEL_LHU, LS_SEL_SH: sz = 2'd1;
      default:                          sz = 2'd2;
    endcase
    return sz;
  endfunction

  state_e            state_q, state_d;
  logic [3:0]        sel_q, sel_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              rvalid_q, rvalid_d;
  logic              adel_q, adel_d;
  logic              ades_q, ades_d;
  logic [ADDR_W-1:0] badv_q, badv_d;

  logic       ex_go, ex_mis;
  logic [1:0] ex_size;
  logic [7:0] ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;

  assign ex_go   = ex_ls_ena & sel_known(ex_ls_sel) & ~flush;
  assign ex_size = sel_size(ex_ls_sel);
  assign ex_mis  = ((ex_size == 2'd1) & ex_addr[0]) |
                   ((ex_size == 2'd2) & (ex_addr[1:0] != 2'b00));

  // Load extraction and extension from the returned word.
  always_comb begin
    ld_byte = data_rdata[{addr_q[1:0], 3'b000} +: 8];
    ld_half = addr_q[1] ? data_rdata[31:16] : data_rdata[15:0];
    case (sel_q)
      LS_SEL_LB:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      LS_SEL_LBU: ld_data = {24'd0, ld_byte};
      LS_SEL_LH:  ld_data = {{16{ld_half[15]}}, ld_half};
      LS_SEL_LHU: ld_data = {16'd0, ld_half};
      default:    ld_data = data_rdata;
    endcase
  end

  // Bus request fields derived from the captured op.
  always_comb begin
    data_req   = (state_q == S_REQ);
    data_wr    = sel_store(sel_q);
    data_size  = sel_size(sel_q);
    data_addr  = addr_q;
    data_wstrb = 4'b0000;
    data_wdata = wdata_q;
    case (sel_q)
      LS_SEL_SB: begin
        data_wstrb = 4'b0001 << addr_q[1:0];
        data_wdata = {4{wdata_q[7:0]}};
      end
      LS_SEL_SH: begin
        data_wstrb = addr_q[1] ? 4'b1100 : 4'b0011;
        data_wdata = {2{wdata_q[15:0]}};
      end
      LS_SEL_SW: data_wstrb = 4'b1111;
      default: ;
    endcase
  end

  // Next-state, capture and result/exception pulse logic.
  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    rvalid_d = 1'b0;
    adel_d   = 1'b0;
    ades_d   = 1'b0;
    badv_d   = badv_q;
    case (state_q)
      S_IDLE: begin
        if (ex_go) begin
          if (ex_mis) begin
            adel_d = ~sel_store(ex_ls_sel);
            ades_d = sel_store(ex_ls_sel);
            badv_d = ex_addr;
          end else begin
            sel_d   = ex_ls_sel;
            addr_d  = ex_addr;
            wdata_d = ex_wdata;
            state_d = S_REQ;
          end
        end
      end
      S_REQ: begin
        if (data_addr_ok) state_d = flush ? S_DRAIN : S_WAIT;
        else if (flush)   state_d = S_IDLE;
      end
      S_WAIT: begin
        // A flush coinciding with data_ok kills the result; the bus is already done.
        if (data_data_ok) begin
          state_d = S_IDLE;
          if (!flush) begin
            rvalid_d = 1'b1;
            rdata_d  = sel_store(sel_q) ? 32'd0 : ld_data;
          end
        end else if (flush) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (data_data_ok) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Stall is combinational so the pipeline releases in the data_ok cycle.
  assign lsu_stall = ((state_q == S_IDLE) & ex_go & ~ex_mis) |
                     (state_q == S_REQ) |
                     ((state_q == S_WAIT) & ~data_data_ok) |
                     (state_q == S_DRAIN);

  // State and captured-request registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      sel_q    <= 4'd0;
      addr_q   <= '0;
      wdata_q  <= 32'd0;
      rdata_q  <= 32'd0;
      rvalid_q <= 1'b0;
      adel_q   <= 1'b0;
      ades_q   <= 1'b0;
      badv_q   <= '0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      adel_q   <= adel_d;
      ades_q   <= ades_d;
      badv_q   <= badv_d;
    end
  end

  assign mem_r_data  = rdata_q;
  assign mem_r_valid = rvalid_q;
  assign ls_adel     = adel_q;
  assign ls_ades     = ades_q;
  assign ls_badvaddr = badv_q;

`ifdef LSU_PERF_CNT_EN
  logic done_ok;
  assign done_ok = (state_q == S_WAIT) & data_data_ok & ~flush;

  // Free-running performance counters, wrapping at 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_loads        <= 32'd0;
      perf_stores       <= 32'd0;
      perf_stall_cycles <= 32'd0;
    end else begin
      if (done_ok & ~sel_store(sel_q)) perf_loads  <= perf_loads + 32'd1;
      if (done_ok &  sel_store(sel_q)) perf_stores <= perf_stores + 32'd1;
      if (lsu_stall) perf_stall_cycles <= perf_stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_lsu_sram.sv
// Testbench for lsu_sram: directed scenarios plus random ops, a latency-
// programmable bus responder, and a scoreboard-driven result monitor.
module tb_lsu_sram;
  localparam int LB = 0, LBU = 1, LH = 2, LHU = 3, LW = 4, SB = 5, SH = 6, SW = 7;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_ls_ena;
  logic [3:0]  ex_ls_sel;
  logic [31:0] ex_addr;
  logic [31:0] ex_wdata;
  logic        flush;
  logic        lsu_stall;
  logic [31:0] mem_r_data;
  logic        mem_r_valid;
  logic        ls_adel, ls_ades;
  logic [31:0] ls_badvaddr;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr, data_wdata;
  logic        data_addr_ok;
  logic [31:0] data_rdata;
  logic        data_data_ok;
`ifdef LSU_PERF_CNT_EN
  logic [31:0] perf_loads, perf_stores, perf_stall_cycles;
`endif

  always #5 clk = ~clk;

  lsu_sram #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .ex_ls_ena(ex_ls_ena), .ex_ls_sel(ex_ls_sel),
    .ex_addr(ex_addr), .ex_wdata(ex_wdata), .flush(flush),
    .lsu_stall(lsu_stall), .mem_r_data(mem_r_data), .mem_r_valid(mem_r_valid),
    .ls_adel(ls_adel), .ls_ades(ls_ades), .ls_badvaddr(ls_badvaddr),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_wstrb(data_wstrb), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_rdata(data_rdata),
`ifdef LSU_PERF_CNT_EN
    .perf_loads(perf_loads), .perf_stores(perf_stores),
    .perf_stall_cycles(perf_stall_cycles),
`endif
    .data_data_ok(data_data_ok)
  );

  typedef struct {
    int          sel;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          a_lat;
    int          d_lat;
    int          flush_at;
  } op_t;

  typedef struct {
    int          kind;   // 0 result, 1 adel, 2 ades
    logic [31:0] val;
  } exp_t;

  exp_t        exp_q[$];
  op_t         cur;
  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] last_res = 32'd0;
  bit          mon_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: plain arithmetic on byte counts and offsets.
  function automatic int nbytes(input int s);
    if (s == LB || s == LBU || s == SB) return 1;
    if (s == LH || s == LHU || s == SH) return 2;
    return 4;
  endfunction

  function automatic bit is_st(input int s);
    return s >= SB;
  endfunction

  function automatic bit misal(input int s, input logic [31:0] a);
    return (a % nbytes(s)) != 0;
  endfunction

  function automatic logic [31:0] ref_load(input int s, input logic [31:0] a, input logic [31:0] rd);
    longint v, span;
    int n;
    n = nbytes(s);
    span = longint'(1) << (8 * n);
    v = (longint'(rd) >> (8 * (a % 4))) % span;
    if ((s == LB || s == LH) && v >= span / 2) v = v - span;
    return v[31:0];
  endfunction

  function automatic logic [31:0] ref_strb(input int s, input logic [31:0] a);
    longint m;
    if (!is_st(s)) return 32'd0;
    m = ((longint'(1) << nbytes(s)) - 1) << (a % 4);
    return m[31:0];
  endfunction

  function automatic logic [31:0] ref_wdata(input int s, input logic [31:0] w);
    logic [31:0] r;
    int n;
    n = nbytes(s);
    r = 32'd0;
    for (int i = 0; i < 4; i++) r = r | (((w >> (8 * (i % n))) & 32'hFF) << (8 * i));
    return r;
  endfunction

  function automatic logic [31:0] ref_size(input int s);
    int n;
    n = nbytes(s);
    return (n == 1) ? 32'd0 : (n == 2) ? 32'd1 : 32'd2;
  endfunction

  function automatic op_t mk(input int s, input logic [31:0] a, input logic [31:0] w,
                             input logic [31:0] rd, input int al, input int dl, input int fa);
    op_t o;
    o.sel = s; o.addr = a; o.wdata = w; o.rdata = rd;
    o.a_lat = al; o.d_lat = dl; o.flush_at = fa;
    return o;
  endfunction

  // Bus responder: addr_ok after a_lat cycles of req, data_ok d_lat cycles after acceptance.
  initial begin
    bit in_req = 1'b0;
    bit phase = 1'b0;
    int acnt = 0;
    int dcnt = 0;
    data_addr_ok = 1'b0;
    data_data_ok = 1'b0;
    data_rdata   = 32'd0;
    forever begin
      @(posedge clk);
      #1;
      if (data_data_ok) begin
        data_data_ok = 1'b0;
        phase = 1'b0;
      end
      if (data_addr_ok) begin
        data_addr_ok = 1'b0;
        phase = 1'b1;
        dcnt = cur.d_lat;
      end
      data_rdata = $urandom();
      if (phase) begin
        if (dcnt == 0) begin
          data_data_ok = 1'b1;
          data_rdata = cur.rdata;
        end else dcnt--;
      end else if (data_req) begin
        if (!in_req) begin
          in_req = 1'b1;
          acnt = cur.a_lat;
        end
        if (acnt == 0) begin
          data_addr_ok = 1'b1;
          in_req = 1'b0;
          check("data_wr", {31'd0, data_wr}, {31'd0, is_st(cur.sel)});
          check("data_size", {30'd0, data_size}, ref_size(cur.sel));
          check("data_addr", data_addr, cur.addr);
          check("data_wstrb", {28'd0, data_wstrb}, ref_strb(cur.sel, cur.addr));
          if (is_st(cur.sel)) check("data_wdata", data_wdata, ref_wdata(cur.sel, cur.wdata));
        end else acnt--;
      end else begin
        in_req = 1'b0;
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents a result or exception.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (mem_r_valid) begin
          if (exp_q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL unexpected_result: got 0x%08h expected none at %0t", mem_r_data, $time);
          end else begin
            e = exp_q.pop_front();
            check("result kind", 32'd0, e.kind);
            check("mem_r_data", mem_r_data, e.val);
            last_res = e.val;
          end
        end else begin
          check("mem_r_data hold", mem_r_data, last_res);
        end
        if (ls_adel || ls_ades) begin
          if (exp_q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL unexpected_exception: got adel=%0b ades=%0b expected none at %0t",
                     ls_adel, ls_ades, $time);
          end else begin
            e = exp_q.pop_front();
            check("exception kind", {30'd0, ls_ades, ls_adel}, e.kind);
            check("ls_badvaddr", ls_badvaddr, e.val);
          end
        end
      end
    end
  end

  // Issue one op, honouring lsu_stall, optional flush, and push its expectation.
  task automatic run_op(input op_t o);
    int  c;
    bit  mis;
    bit  flushed;
    exp_t e;
    cur = o;
    mis = misal(o.sel, o.addr);
    flushed = (o.flush_at >= 0);
    ex_ls_ena = 1'b1;
    ex_ls_sel = 4'(o.sel);
    ex_addr   = o.addr;
    ex_wdata  = o.wdata;
    flush     = (o.flush_at == 0);
    if (mis) begin
      e.kind = is_st(o.sel) ? 2 : 1;
      e.val  = o.addr;
      exp_q.push_back(e);
    end else if (!flushed) begin
      e.kind = 0;
      e.val  = is_st(o.sel) ? 32'd0 : ref_load(o.sel, o.addr, o.rdata);
      exp_q.push_back(e);
    end
    c = 0;
    forever begin
      @(negedge clk);
      if (!lsu_stall) break;
      if (c > 60) begin
        n_checks++; n_fail++;
        $display("FAIL stall_timeout: got stall after %0d cycles expected release", c);
        break;
      end
      @(posedge clk);
      #1;
      c++;
      flush = flushed && (c == o.flush_at);
      if (flushed && c > o.flush_at) ex_ls_ena = 1'b0;
    end
    if (mis) check("stall cycles (misaligned)", c, 0);
    else if (!flushed) check("stall cycles", c, 2 + o.a_lat + o.d_lat);
    @(posedge clk);
    #1;
    ex_ls_ena = 1'b0;
    flush = 1'b0;
    if (mis) check("no data_req on misaligned", {31'd0, data_req}, 32'd0);
  endtask

  initial begin
    op_t dir[$];
    op_t o;
    rst = 1'b1;
    ex_ls_ena = 1'b0;
    ex_ls_sel = 4'd0;
    ex_addr = 32'd0;
    ex_wdata = 32'd0;
    flush = 1'b0;
    cur = mk(LW, 32'd0, 32'd0, 32'd0, 0, 0, -1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset lsu_stall", {31'd0, lsu_stall}, 32'd0);
    check("reset mem_r_valid", {31'd0, mem_r_valid}, 32'd0);
    check("reset mem_r_data", mem_r_data, 32'd0);
    check("reset ls_adel/ades", {30'd0, ls_ades, ls_adel}, 32'd0);
    check("reset ls_badvaddr", ls_badvaddr, 32'd0);
    check("reset data_req", {31'd0, data_req}, 32'd0);
    check("reset data_wstrb", {28'd0, data_wstrb}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    mon_en = 1'b1;

    dir.push_back(mk(LB,  32'h0000_1003, 32'h0,         32'h80FF_1234, 1, 1, -1));
    dir.push_back(mk(SH,  32'h0000_2002, 32'h1234_ABCD, 32'hDEAD_BEEF, 0, 1, -1));
    dir.push_back(mk(LW,  32'h0000_3001, 32'h0,         32'h0,         0, 0, -1));
    dir.push_back(mk(SW,  32'h0000_3002, 32'h5555_AAAA, 32'h0,         0, 0, -1));
    dir.push_back(mk(LHU, 32'h0000_4002, 32'h0,         32'hBEEF_0000, 0, 5, -1));
    dir.push_back(mk(LW,  32'h0000_5000, 32'h0,         32'h1111_2222, 0, 4, 3));
    dir.push_back(mk(LW,  32'h0000_5004, 32'h0,         32'hCAFE_F00D, 1, 0, -1));
    dir.push_back(mk(SB,  32'h0000_0010, 32'hA5A5_A55A, 32'h0,         0, 0, -1));
    dir.push_back(mk(LBU, 32'h0000_0010, 32'h0,         32'h1122_335A, 0, 0, -1));
    dir.push_back(mk(LH,  32'h0000_0006, 32'h0,         32'h8001_7FFF, 2, 0, -1));
    dir.push_back(mk(LW,  32'h0000_0008, 32'h0,         32'h0,         2, 1, 1));
    foreach (dir[i]) run_op(dir[i]);

    for (int i = 0; i < 200; i++) begin
      o.sel   = int'($urandom_range(0, 7));
      o.addr  = $urandom();
      o.wdata = $urandom();
      o.rdata = $urandom();
      o.a_lat = int'($urandom_range(0, 3));
      o.d_lat = int'($urandom_range(0, 4));
      o.flush_at = -1;
      if (!misal(o.sel, o.addr) && ($urandom_range(0, 7) == 0))
        o.flush_at = int'($urandom_range(0, 1 + o.a_lat + o.d_lat));
      run_op(o);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end

    repeat (10) @(posedge clk);
    #1;
    check("scoreboard drained", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lsu_sram.md
Name: lsu_sram

Overview:
Parametrised successor to the combinational load/store unit. It converts EX-stage load/store requests into a handshaked SRAM-like data bus (req/addr_ok/data_ok) with variable latency. It performs byte-lane alignment and load extraction from address offset bits, detects misaligned accesses, and stalls the pipeline until the access completes. It sits between the EX/MEM pipeline registers and the data-cache/bus bridge.

Parameters:
ADDR_W, 32, data bus address width (>=3).
DATA_W, 32, data width; fixed 32 for this generation (4 byte lanes); other values are illegal and raise an elaboration error.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
ex_ls_ena  in  1  EX stage issues a load/store this cycle; held stable while lsu_stall=1
ex_ls_sel  in  4  operation, encoded with the LS_SEL_* codes (LB LBU LH LHU LW SB SH SW) from the ID definitions header
ex_addr  in  ADDR_W  effective address (EX alu result)
ex_wdata  in  32  store data (rt)
flush  in  1  kill the in-flight access (exception/redirect)
lsu_stall  out  1  pipeline hold request
mem_r_data  out  32  extracted, extended load result
mem_r_valid  out  1  one-cycle pulse: mem_r_data valid
ls_adel  out  1  misaligned load exception, one-cycle pulse
ls_ades  out  1  misaligned store exception, one-cycle pulse
ls_badvaddr  out  ADDR_W  faulting address, registered with ades/adel
data_req  out  1  bus request
data_wr  out  1  1=store
data_size  out  2  0=byte 1=half 2=word
data_wstrb  out  4  byte write strobes (0 for loads)
data_addr  out  ADDR_W  bus address (unaligned low bits passed through)
data_wdata  out  32  lane-replicated store data
data_addr_ok  in  1  request accepted
data_rdata  in  32  read data (full word)
data_data_ok  in  1  response returned

Behaviour:
- States: IDLE, REQ, WAIT, DRAIN. Reset -> IDLE; all outputs 0; captured request registers 0.
- Misalign: halfword ops with addr[0]=1; word ops with addr[1:0]!=0. Byte ops never misalign.
- IDLE with ex_ls_ena=1 and flush=0:
  - If misaligned: no bus request. Next cycle pulse ls_adel (loads) or ls_ades (stores) and load ls_badvaddr. Stay in IDLE. No stall.
  - If aligned: capture sel, addr, wdata and go to REQ.
- Flush in IDLE: the op is ignored.
- REQ: data_req=1 with the captured fields. When data_addr_ok=1, go to WAIT. With flush=1 and addr_ok=0, drop the request and go to IDLE. With flush=1 and addr_ok=1, go to DRAIN.
- WAIT: data_data_ok is sampled only in this state (data_ok in REQ is ignored; the bus never returns data in the addr_ok cycle). When data_ok=1, register the extracted load into mem_r_data and pulse mem_r_valid next cycle (also for stores, with mem_r_data=0), then go to IDLE. flush=1 in WAIT goes to DRAIN.
- DRAIN: wait for data_ok, discard the data, no mem_r_valid, then go to IDLE. Bus transactions are never abandoned after addr_ok.
- lsu_stall = (IDLE & ex_ls_ena & aligned & !flush) | REQ | (WAIT & !data_data_ok) | DRAIN. It deasserts in the data_ok cycle, so result latency is at least 3 cycles from issue.
- Strobes: SB 4'b0001<<addr[1:0]; SH 4'b0011<<{addr[1],1'b0}; SW 4'b1111.
- Write data replication: SB {4{b}}; SH {2{h}}; SW word.
- Load extraction: byte = rdata[8*addr[1:0] +: 8]; half = rdata[16*addr[1] +: 16]. LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- mem_r_data holds its value until the next valid result.
- A new ex_ls_ena in the cycle after completion is accepted normally (back-to-back).
- rst mid-transaction returns to IDLE immediately. The bus must be reset by the same rst.

Optional Feature:
LSU_PERF_CNT_EN:
- Defined: adds outputs perf_loads, perf_stores, perf_stall_cycles (32-bit each, wrap at 2^32, reset to 0).
  - perf_loads / perf_stores count on completed (non-flushed, non-misaligned) data_ok.
  - perf_stall_cycles counts cycles with lsu_stall=1.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- LB at 0x1003, bus rdata=0x80FF_1234, addr_ok after 1 cycle, data_ok after 2 -> data_size=0, wstrb=0; mem_r_data=0xFFFF_FF80 with mem_r_valid for one cycle; stall for exactly the request duration.
- SH at 0x2002, wdata=0x1234_ABCD -> data_wr=1, wstrb=4'b1100, data_wdata=0xABCD_ABCD, size=1; mem_r_valid pulse, mem_r_data=0.
- LW at 0x3001 -> no data_req, ls_adel=1 and ls_badvaddr=0x3001 one cycle later, lsu_stall never asserted; SW at 0x3002 -> ls_ades=1.
- LHU at 0x4002, data_ok stalled 5 cycles, rdata=0xBEEF_0000 -> mem_r_data=0x0000_BEEF; lsu_stall high throughout WAIT.
- Flush in WAIT of an LW -> DRAIN; stall held until data_ok; no mem_r_valid; the next LW issues cleanly afterward.
- Back-to-back SB 0x10 then LBU 0x10 (bus returns written byte 0x5A) -> second request starts the cycle after the first completes; result 0x0000_005A.
